// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: widths, FSM encoding,
// bubble constant and hold-buffer packing helper.
package inst_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned HOLD_W = ADDR_W + INST_W;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    // Address sits in the upper half so a hold entry reads as {addr, inst}.
    function automatic logic [HOLD_W-1:0] pack_hold(input logic [ADDR_W-1:0] addr,
                                                    input logic [INST_W-1:0] inst);
        return {addr, inst};
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Instruction memory request/acknowledge bus between the fetch controller and memory.
interface inst_fetch_ctrl_if;
    import inst_fetch_ctrl_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [INST_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/inst_fetch_ctrl_fetch_hold_buf.sv
// Hold buffer: parks one fetched {addr, inst} pair while decode is stalled.
module fetch_hold_buf
    import inst_fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [HOLD_W-1:0] data_i,
    output logic [HOLD_W-1:0] data_o,
    output logic              valid_o
);

    logic [HOLD_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues one memory request per PC value and
// delivers the result to the IF/ID register, handling stall, flush and reset.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ce_i,
    input  logic [ADDR_W-1:0]   pc_addr_i,
    input  logic                stall_i,
    input  logic                flush_i,
    inst_fetch_ctrl_if.master   mem_io,
    output logic [INST_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_addr_o,
    output logic                inst_valid_o,
    output logic                stall_req_o
);

    fetch_state_e      state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              discard_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_addr_q;
    logic              inst_valid_q;

    logic              ack_usable;
    logic              buf_load;
    logic              buf_clear;
    logic [HOLD_W-1:0] buf_data;
    logic              buf_valid;

    // An ack only carries a deliverable instruction if nothing has killed the fetch.
    assign ack_usable = mem_io.mem_ack && !discard_q && !flush_i;

    always_comb begin
        buf_load  = (state_q == StWait) && ack_usable && stall_i;
        buf_clear = (state_q == StHold) && (flush_i || !stall_i);
    end

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (pack_hold(mem_addr_q, mem_io.mem_rdata)),
        .data_o  (buf_data),
        .valid_o (buf_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            discard_q    <= 1'b0;
            inst_q       <= NOP_INST;
            inst_addr_q  <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            // Baseline IF/ID policy; a state below may load a real instruction over it.
            if (flush_i) begin
                inst_valid_q <= 1'b0;
                inst_q       <= NOP_INST;
            end else if (!stall_i) begin
                inst_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (ce_i && !flush_i) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_addr_i;
                        discard_q  <= 1'b0;
                        state_q    <= StWait;
                    end else begin
                        mem_req_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (mem_io.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StIdle;
                        if (ack_usable) begin
                            if (stall_i) begin
                                state_q <= StHold;
                            end else begin
                                inst_q       <= mem_io.mem_rdata;
                                inst_addr_q  <= mem_addr_q;
                                inst_valid_q <= 1'b1;
                            end
                        end
                    end else if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (!stall_i && buf_valid) begin
                        inst_q       <= buf_data[INST_W-1:0];
                        inst_addr_q  <= buf_data[HOLD_W-1:INST_W];
                        inst_valid_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stall_req_o = 1'b0;
        if (ce_i) begin
            case (state_q)
                StIdle:  stall_req_o = 1'b1;
                StWait:  stall_req_o = !ack_usable;
                default: stall_req_o = 1'b0;
            endcase
        end
    end

    assign mem_io.mem_req  = mem_req_q;
    assign mem_io.mem_addr = mem_addr_q;
    assign inst_o          = inst_q;
    assign inst_addr_o     = inst_addr_q;
    assign inst_valid_o    = inst_valid_q;

endmodule
